// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and datapath control outputs of the stopwatch mode controller.
// Latency: none, plain wires grouped for port convenience.
// Backpressure: none, all signals are level/strobe signals without handshake.
interface stopwatch_ctrl_if;
    logic key_start_pause;
    logic key_display_stop;
    logic count_en;
    logic tick;
    logic display_en;
    logic counter_clear;
    logic led0;
    logic led1;
    logic led2;
    logic led3;

    // Controller side: samples the raw keys, drives the datapath controls.
    modport master (
        input  key_start_pause, key_display_stop,
        output count_en, tick, display_en, counter_clear,
        output led0, led1, led2, led3
    );

    // Key/datapath side: drives the raw keys, consumes the controls.
    modport slave (
        output key_start_pause, key_display_stop,
        input  count_en, tick, display_en, counter_clear,
        input  led0, led1, led2, led3
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM with key debounce and 10 ms tick prescaler.
// Latency: key press to state change DEBOUNCE_CYCLES+3 clk edges; tick/clear registered.
// Backpressure: none; outputs are free-running strobes and levels.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_CYCLES     = 500000
) (
    input  logic             clk,
    input  logic             key_reset,
    stopwatch_ctrl_if.master sw
);
    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_LAP    = 3'd2,
        ST_LPAUSE = 3'd3,
        ST_PAUSE  = 3'd4
    } state_t;

    // Bit 0 = start/pause key, bit 1 = display/stop key; 1 = released.
    logic [1:0]       raw_keys;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       deb_dly_q;
    logic [1:0][31:0] deb_cnt_q, deb_cnt_d;
    logic             start_press, disp_press;

    state_t           state_q, state_d;
    logic             clear_q, clear_d;
    logic [31:0]      presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             count_en, display_en;

    assign raw_keys = {sw.key_display_stop, sw.key_start_pause};

    // Synchronize raw keys and hold the stable-level filter state.
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            deb_q     <= 2'b11;
            deb_dly_q <= 2'b11;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= raw_keys;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Accept a new key level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (deb_cnt_q[k] == DEB_LAST) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + 32'd1;
                end
            end
        end
    end

    // Falling edge of the debounced level is a press; releases are ignored.
    assign start_press = deb_dly_q[0] & ~deb_q[0];
    assign disp_press  = deb_dly_q[1] & ~deb_q[1];

    // State, clear strobe and prescaler registers.
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            state_q <= ST_IDLE;
            clear_q <= 1'b1;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // Mode transitions; a start press in the same cycle masks a display press.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (start_press) begin
            case (state_q)
                ST_IDLE:   state_d = ST_RUN;
                ST_RUN:    state_d = ST_PAUSE;
                ST_LAP:    state_d = ST_LPAUSE;
                ST_LPAUSE: state_d = ST_LAP;
                ST_PAUSE:  state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end else if (disp_press) begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_RUN:    state_d = ST_LAP;
                ST_LAP:    state_d = ST_RUN;
                ST_LPAUSE: state_d = ST_PAUSE;
                ST_PAUSE: begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Decode datapath enables directly from the current state.
    always_comb begin
        count_en   = 1'b0;
        display_en = 1'b1;
        case (state_q)
            ST_RUN:    count_en = 1'b1;
            ST_LAP: begin
                count_en   = 1'b1;
                display_en = 1'b0;
            end
            ST_LPAUSE: display_en = 1'b0;
            default: begin
                count_en   = 1'b0;
                display_en = 1'b1;
            end
        endcase
    end

    // Prescaler advances only while counting, so paused time keeps its fraction.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clear_d) begin
            presc_d = '0;
        end else if (count_en) begin
            if (presc_q == TICK_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    assign sw.count_en      = count_en;
    assign sw.display_en    = display_en;
    assign sw.tick          = tick_q;
    assign sw.counter_clear = clear_q;
    assign sw.led0          = count_en;
    assign sw.led1          = ~display_en;
    assign sw.led2          = ~deb_q[0];
    assign sw.led3          = ~deb_q[1];
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller and timebase for the stopwatch counter/display datapath. It debounces the start/pause and display keys and runs the stopwatch mode state machine: idle, run, lap (display frozen), lap-pause and pause. It drives the datapath's count enable, 10 ms tick, display-update enable, synchronous counter clear and status LEDs. The BCD counter chain and the seven-segment decoders consume these outputs.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles before a key level is accepted (20 ms at 50 MHz); must be >= 2.
- TICK_CYCLES, 500000: clock cycles per counting tick (10 ms at 50 MHz); must be >= 2.
- clk  in  1  system clock, 50 MHz.
- key_reset  in  1  asynchronous, active-low reset; one clock domain (clk).
- key_start_pause  in  1  raw key, low = pressed, asynchronous to clk.
- key_display_stop  in  1  raw key, low = pressed, asynchronous to clk.
- count_en  out  1  counter chain may advance.
- tick  out  1  one-cycle advance strobe for the least-significant counter digit.
- display_en  out  1  display registers track the counters when 1 and hold when 0.
- counter_clear  out  1  one-cycle synchronous clear of counters and display registers.
- led0..led3  out  1 each  led0 = count_en, led1 = ~display_en, led2 = debounced start key pressed, led3 = debounced display key pressed.

## Operation
- Key path, per key: 2-flop synchronizer, then a stable-level filter with a 32-bit counter.
  - While the synchronized level differs from the debounced level, the counter increments; otherwise it clears to 0.
  - After the levels differ for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value and the counter clears.
- Press event: debounced level 1->0. It is detected by comparing against a 1-cycle delayed copy and is one cycle wide. Releases produce no event. A held key produces exactly one event. Glitches shorter than DEBOUNCE_CYCLES produce none.
- States and their outputs:
  - IDLE: count_en 0, display_en 1.
  - RUN: count_en 1, display_en 1.
  - LAP: count_en 1, display_en 0.
  - LPAUSE: count_en 0, display_en 0.
  - PAUSE: count_en 0, display_en 1.
- Transitions (S = start press, D = display press):
  - IDLE: S->RUN; D ignored.
  - RUN: S->PAUSE; D->LAP.
  - LAP: S->LPAUSE; D->RUN.
  - LPAUSE: S->LAP; D->PAUSE.
  - PAUSE: S->RUN; D->IDLE and pulse counter_clear.
- Simultaneous S and D in one cycle: S wins, D is discarded.
- Prescaler: 32-bit, counts 0..TICK_CYCLES-1 only while count_en = 1.
  - tick asserts for one cycle each time the prescaler wraps.
  - In LPAUSE/PAUSE the prescaler holds its value, so the fractional interval is preserved on resume.
  - counter_clear also clears the prescaler.
- count_en, display_en and led0/led1 are decoded from the state register and change with it. tick and counter_clear are registered.

## Timing
- Reset (key_reset low, asynchronous):
  - state IDLE; count_en 0; display_en 1; tick 0; counter_clear 1; all LEDs 0.
  - Synchronizers and debounced levels at 1 (released); debounce counters and prescaler at 0.
- counter_clear deasserts at the first clk edge after key_reset rises. The datapath therefore sees exactly one clear cycle after reset.
- Reset mid-operation in any state: outputs return to reset values immediately, without waiting for clk.
- A key held low across reset release is accepted as a press after debounce.
- Key latency: let edge 1 be the first clk edge sampling a stable new raw level.
  - The debounced level changes at edge DEBOUNCE_CYCLES+2.
  - State and the decoded outputs change at edge DEBOUNCE_CYCLES+3.
- Tick timing:
  - The first tick after entering RUN from IDLE is high in the cycle after edge TICK_CYCLES following the state change.
  - Later ticks are exactly TICK_CYCLES cycles apart while count_en = 1.
  - Time spent paused is not counted.
- PAUSE->IDLE: counter_clear is high for exactly the one cycle in which state first reads IDLE.
- tick never asserts in the same cycle as counter_clear.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, TICK_CYCLES = 10.
- Reset release, no keys:
  - counter_clear high for 1 cycle, then 0.
  - state IDLE, count_en 0, display_en 1, no tick over 100 cycles.
- Start press held for 20 cycles:
  - RUN entered at edge 7.
  - ticks every 10 cycles.
  - a single event only; release gives no transition.
- Glitch rejection: 3-cycle low pulse on key_start_pause -> no state change, led2 stays 0.
- Full cycle:
  - Step through RUN, D->LAP (display_en 0, ticks continue), S->LPAUSE (ticks stop), D->PAUSE (display_en 1), D->IDLE.
  - Check counter_clear pulses once, and the prescaler holds its value across the pause.
- Both keys pressed in the same cycle from RUN -> PAUSE only, and display_en stays 1.
- key_reset asserted mid-LAP between clk edges -> outputs go to reset values before the next edge, and counter_clear is high.
